// File: rtl/mac512_pkg.sv
// Shared types and sizing for the MAC512 round-robin scheduler.
package mac512_pkg;

  localparam int unsigned W       = 256;
  localparam int unsigned RW      = 2 * W;
  localparam int unsigned MAC_LAT = 257;
  localparam int unsigned CNT_W   = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    CAPT  = 3'd3,
    HOLD  = 3'd4
  } state_e;

  typedef logic req_id_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         acc;
  } req_t;

  typedef struct packed {
    logic [RW-1:0] data;
    req_id_t       id;
  } res_t;

  // Accumulation is only honoured onto the same requester's previous result.
  function automatic logic acc_hit(input logic acc, input logic last_vld,
                                   input req_id_t last_id, input req_id_t id);
    return acc && last_vld && (last_id == id);
  endfunction

endpackage

// File: rtl/mac512_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the winner on accept.
module mac512_rr_arb2
  import mac512_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_vld,
  input  logic       accept,
  output logic       gnt_vld_c,
  output req_id_t    gnt_id_c
);

  req_id_t rr_ptr_q;
  req_id_t rr_ptr_d;

  // A lone requester wins outright; contention falls back to the pointer.
  always_comb begin
    gnt_vld_c = |req_vld;
    gnt_id_c  = rr_ptr_q;
    if (req_vld == 2'b01) begin
      gnt_id_c = 1'b0;
    end else if (req_vld == 2'b10) begin
      gnt_id_c = 1'b1;
    end
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~gnt_id_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/mac512_rr_sched.sv
// Shares one shift-add MAC512 between two requesters: arbitrate, clear or
// accumulate, run the MAC for MAC_LAT cycles, then hold the tagged result.
module mac512_rr_sched
  import mac512_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [W-1:0]  req0_a,
  input  logic [W-1:0]  req0_b,
  input  logic          req0_acc,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [W-1:0]  req1_a,
  input  logic [W-1:0]  req1_b,
  input  logic          req1_acc,
  output logic [W-1:0]  mac_a,
  output logic [W-1:0]  mac_b,
  output logic          mac_en,
  output logic          mac_rst_n,
  input  logic [RW-1:0] mac_out,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          res_id
);

  state_e           state_q,     state_d;
  logic [W-1:0]     mac_a_q,     mac_a_d;
  logic [W-1:0]     mac_b_q,     mac_b_d;
  logic             mac_en_q,    mac_en_d;
  logic             mac_rst_n_q, mac_rst_n_d;
  logic             res_valid_q, res_valid_d;
  res_t             res_q,       res_d;
  req_id_t          cur_id_q,    cur_id_d;
  logic             last_vld_q,  last_vld_d;
  req_id_t          last_id_q,   last_id_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic    gnt_vld_c;
  req_id_t gnt_id_c;
  logic    accept_c;
  req_t    req0_s;
  req_t    req1_s;
  req_t    gnt_req_c;

  assign req0_s    = '{a: req0_a, b: req0_b, acc: req0_acc};
  assign req1_s    = '{a: req1_a, b: req1_b, acc: req1_acc};
  assign gnt_req_c = gnt_id_c ? req1_s : req0_s;

  // Requests are only taken while idle; ready is the grant qualified by state.
  assign accept_c   = (state_q == IDLE) && gnt_vld_c;
  assign req0_ready = accept_c && (gnt_id_c == 1'b0);
  assign req1_ready = accept_c && (gnt_id_c == 1'b1);

  mac512_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_vld   ({req1_valid, req0_valid}),
    .accept    (accept_c),
    .gnt_vld_c (gnt_vld_c),
    .gnt_id_c  (gnt_id_c)
  );

  // Next-state logic; MAC controls are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_en_d    = 1'b0;
    mac_rst_n_d = 1'b1;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    cur_id_d    = cur_id_q;
    last_vld_d  = last_vld_q;
    last_id_d   = last_id_q;
    cnt_d       = '0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          mac_a_d  = gnt_req_c.a;
          mac_b_d  = gnt_req_c.b;
          cur_id_d = gnt_id_c;
          if (acc_hit(gnt_req_c.acc, last_vld_q, last_id_q, gnt_id_c)) begin
            state_d  = RUN;
            mac_en_d = 1'b1;
          end else begin
            state_d     = CLEAR;
            mac_rst_n_d = 1'b0;
          end
        end
      end
      CLEAR: begin
        state_d  = RUN;
        mac_en_d = 1'b1;
      end
      RUN: begin
        if (cnt_q == CNT_W'(MAC_LAT - 1)) begin
          state_d = CAPT;
        end else begin
          mac_en_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      CAPT: begin
        res_d.data  = mac_out;
        res_d.id    = cur_id_q;
        last_id_d   = cur_id_q;
        last_vld_d  = 1'b1;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      cur_id_q    <= 1'b0;
      last_vld_q  <= 1'b0;
      last_id_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_en_q    <= mac_en_d;
      mac_rst_n_q <= mac_rst_n_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      cur_id_q    <= cur_id_d;
      last_vld_q  <= last_vld_d;
      last_id_q   <= last_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_en    = mac_en_q;
  assign mac_rst_n = mac_rst_n_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q.data;
  assign res_id    = res_q.id;

endmodule

// File: tb/tb_mac512_rr_sched.sv
// Bench for mac512_rr_sched: behavioural shift-add MAC plus a result scoreboard.
module tb_mac512_rr_sched;

  localparam int unsigned W  = 256;
  localparam int unsigned RW = 512;

  typedef struct packed {
    logic [RW-1:0] data;
    logic          id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req0_ready, req0_acc = 1'b0;
  logic [W-1:0]  req0_a = '0, req0_b = '0;
  logic          req1_valid = 1'b0, req1_ready, req1_acc = 1'b0;
  logic [W-1:0]  req1_a = '0, req1_b = '0;
  logic [W-1:0]  mac_a, mac_b;
  logic          mac_en, mac_rst_n;
  logic [RW-1:0] mac_out;
  logic          res_valid, res_ready = 1'b0, res_id;
  logic [RW-1:0] res_data;

  mac512_rr_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_acc   (req0_acc),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_acc   (req1_acc),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_en     (mac_en),
    .mac_rst_n  (mac_rst_n),
    .mac_out    (mac_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id)
  );

  always #5 clk = ~clk;

  // MAC512 model: 256 partial-product steps then a commit on the 257th enable;
  // any enable beyond that perturbs the accumulator.
  logic [RW-1:0] mac_acc, mac_part;
  int            mac_cnt;
  always @(posedge clk) begin
    if (!mac_rst_n) begin
      mac_acc  <= '0;
      mac_part <= '0;
      mac_cnt  <= 0;
    end else if (mac_en) begin
      if (mac_cnt < 256) begin
        if (mac_b[mac_cnt[7:0]]) mac_part <= mac_part + (RW'(mac_a) << mac_cnt);
      end else if (mac_cnt == 256) begin
        mac_acc <= mac_acc + mac_part;
      end else begin
        mac_acc <= mac_acc + RW'(1);
      end
      mac_cnt <= mac_cnt + 1;
    end else begin
      mac_cnt  <= 0;
      mac_part <= '0;
    end
  end
  assign mac_out = mac_acc;

  int cyc = 0, en_cyc = 0, rstlow_cyc = 0, rdy_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (mac_en) en_cyc <= en_cyc + 1;
      if (!mac_rst_n) rstlow_cyc <= rstlow_cyc + 1;
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) rdy_cyc <= rdy_cyc + 1;
    end
  end

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, n_pop = 0, vld_rise = 0;
  logic vld_prev = 1'b0;

  // Result monitor: each handshake pops and checks the oldest expectation.
  always @(negedge clk) begin
    if (res_valid && !vld_prev) vld_rise = cyc;
    vld_prev = res_valid;
    if (res_valid && res_ready) begin
      n_pop = n_pop + 1;
      if (sb.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL unexpected_result data=%0h id=%0d", res_data, res_id);
      end else begin
        mon_e = sb.pop_front();
        checks = checks + 2;
        if (res_data !== mon_e.data) begin
          errors = errors + 1;
          $display("FAIL res_data got=%0h exp=%0h", res_data, mon_e.data);
        end
        if (res_id !== mon_e.id) begin
          errors = errors + 1;
          $display("FAIL res_id got=%0d exp=%0d", res_id, mon_e.id);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic acc, input logic [RW-1:0] exp_data, input bit push,
                       output int t_rdy);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    if (id) begin req1_a = a; req1_b = b; req1_acc = acc; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_acc = acc; req0_valid = 1'b1; end
    #1;
    while (((id ? req1_ready : req0_ready) !== 1'b1) && n < 600) begin
      @(negedge clk); #1; n++;
    end
    t_rdy = cyc;
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL issue_grant id=%0d ready got=0 exp=1", id);
    end else if (push) begin
      e.data = exp_data; e.id = id;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || res_valid) && n < 800) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 800) begin
      errors++;
      $display("FAIL drain_timeout pending got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks += 8;
    if (mac_en !== 1'b0)    begin errors++; $display("FAIL rst_mac_en got=%0b exp=0", mac_en); end
    if (mac_rst_n !== 1'b0) begin errors++; $display("FAIL rst_mac_rst_n got=%0b exp=0", mac_rst_n); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got=%0b exp=0", res_valid); end
    if (res_data !== '0)    begin errors++; $display("FAIL rst_res_data got=%0h exp=0", res_data); end
    if (res_id !== 1'b0)    begin errors++; $display("FAIL rst_res_id got=%0b exp=0", res_id); end
    if (mac_a !== '0)       begin errors++; $display("FAIL rst_mac_a got=%0h exp=0", mac_a); end
    if (mac_b !== '0)       begin errors++; $display("FAIL rst_mac_b got=%0h exp=0", mac_b); end
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got=%0b%0b exp=00", req1_ready, req0_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mac_rst_n !== 1'b1 || mac_en !== 1'b0) begin
      errors++; $display("FAIL idle_mac_ctrl got=en%0b/rst_n%0b exp=en0/rst_n1", mac_en, mac_rst_n);
    end
  endtask

  task automatic test_single();
    int t, b_en, b_rl, b_rdy;
    res_ready = 1'b1;
    b_en = en_cyc; b_rl = rstlow_cyc; b_rdy = rdy_cyc;
    issue(1'b0, W'(5), W'(10), 1'b0, RW'(50), 1'b1, t);
    wait_drain();
    checks += 4;
    if (en_cyc - b_en != 257)    begin errors++; $display("FAIL single_en_cycles got=%0d exp=257", en_cyc - b_en); end
    if (rstlow_cyc - b_rl != 1)  begin errors++; $display("FAIL single_clear_cycles got=%0d exp=1", rstlow_cyc - b_rl); end
    if (rdy_cyc - b_rdy != 1)    begin errors++; $display("FAIL single_ready_cycles got=%0d exp=1", rdy_cyc - b_rdy); end
    if (vld_rise - t != 260)     begin errors++; $display("FAIL single_latency got=%0d exp=260", vld_rise - t); end
  endtask

  task automatic test_accumulate();
    int t, b_en, b_rl;
    b_en = en_cyc; b_rl = rstlow_cyc;
    issue(1'b0, W'(1), W'(5), 1'b1, RW'(55), 1'b1, t);
    wait_drain();
    checks += 3;
    if (rstlow_cyc - b_rl != 0)  begin errors++; $display("FAIL acc_clear_cycles got=%0d exp=0", rstlow_cyc - b_rl); end
    if (en_cyc - b_en != 257)    begin errors++; $display("FAIL acc_en_cycles got=%0d exp=257", en_cyc - b_en); end
    if (vld_rise - t != 259)     begin errors++; $display("FAIL acc_latency got=%0d exp=259", vld_rise - t); end
    b_rl = rstlow_cyc;
    issue(1'b0, W'(2), W'(2), 1'b0, RW'(4), 1'b1, t);
    wait_drain();
    checks++;
    if (rstlow_cyc - b_rl != 1)  begin errors++; $display("FAIL fresh_clear_cycles got=%0d exp=1", rstlow_cyc - b_rl); end
  endtask

  task automatic test_cross_acc();
    int t, b_rl;
    issue(1'b0, W'(7), W'(1), 1'b0, RW'(7), 1'b1, t);
    wait_drain();
    b_rl = rstlow_cyc;
    issue(1'b1, W'(2), W'(3), 1'b1, RW'(6), 1'b1, t);
    wait_drain();
    checks++;
    if (rstlow_cyc - b_rl != 1)  begin errors++; $display("FAIL cross_clear_cycles got=%0d exp=1", rstlow_cyc - b_rl); end
  endtask

  task automatic test_contention();
    bit [2:0] order;
    logic     gid;
    int       n;
    exp_t     e;
    order = 3'b010;
    apply_reset();
    res_ready = 1'b1;
    @(negedge clk);
    req0_a = W'(3); req0_b = W'(3); req0_acc = 1'b0; req0_valid = 1'b1;
    req1_a = W'(4); req1_b = W'(4); req1_acc = 1'b0; req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 800) begin @(negedge clk); #1; n++; end
      gid = req1_ready;
      checks++;
      if (n >= 800 || (req0_ready && req1_ready) || gid !== order[k]) begin
        errors++;
        $display("FAIL grant_order k=%0d got=%0b%0b exp_id=%0d", k, req1_ready, req0_ready, order[k]);
      end
      e.id   = gid;
      e.data = gid ? RW'(req1_a) * RW'(req1_b) : RW'(req0_a) * RW'(req0_b);
      sb.push_back(e);
      @(posedge clk); #1;
      if (gid) req1_valid = 1'b0;
      else if (k == 0) begin req0_a = W'(2); req0_b = W'(2); end
      else req0_valid = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_back_pressure();
    int   t, n, b_pop;
    exp_t e;
    res_ready = 1'b0;
    issue(1'b0, W'(6), W'(7), 1'b0, RW'(42), 1'b1, t);
    n = 0;
    while (res_valid !== 1'b1 && n < 600) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 600) begin errors++; $display("FAIL bp_valid_timeout got=0 exp=1"); end
    req1_a = W'(3); req1_b = W'(3); req1_acc = 1'b0; req1_valid = 1'b1;
    b_pop = n_pop;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checks += 3;
      if (res_valid !== 1'b1)    begin errors++; $display("FAIL bp_hold_valid i=%0d got=%0b exp=1", i, res_valid); end
      if (res_data !== RW'(42))  begin errors++; $display("FAIL bp_hold_data i=%0d got=%0h exp=2a", i, res_data); end
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_ready i=%0d got=%0b%0b exp=00", i, req1_ready, req0_ready);
      end
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    n = 0;
    @(negedge clk); #1;
    while (req1_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    checks += 2;
    if (res_valid !== 1'b0 || n >= 20) begin
      errors++; $display("FAIL bp_release got=valid%0b exp=valid0 idle", res_valid);
    end
    if (n_pop - b_pop != 1) begin errors++; $display("FAIL bp_transfers got=%0d exp=1", n_pop - b_pop); end
    e.data = RW'(9); e.id = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid_run();
    int t, b_rl, seen;
    res_ready = 1'b1;
    issue(1'b0, W'(9), W'(9), 1'b0, RW'(81), 1'b0, t);
    repeat (101) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (mac_en !== 1'b0)    begin errors++; $display("FAIL midrst_mac_en got=%0b exp=0", mac_en); end
    if (mac_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_mac_rst_n got=%0b exp=0", mac_rst_n); end
    if (mac_a !== '0)       begin errors++; $display("FAIL midrst_mac_a got=%0h exp=0", mac_a); end
    if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got=%0b exp=0", res_valid); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (res_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_lost_result got=%0d exp=0", seen); end
    b_rl = rstlow_cyc;
    issue(1'b0, W'(11), W'(13), 1'b1, RW'(143), 1'b1, t);
    wait_drain();
    checks += 2;
    if (rstlow_cyc - b_rl != 1) begin errors++; $display("FAIL postrst_clear got=%0d exp=1", rstlow_cyc - b_rl); end
    if (vld_rise - t != 260)    begin errors++; $display("FAIL postrst_latency got=%0d exp=260", vld_rise - t); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_accumulate();
    test_cross_acc();
    test_contention();
    test_back_pressure();
    test_reset_mid_run();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
